// File: rtl/vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_receiver
// Brief    : Recovers pixel coordinates from incoming VGA hsync/vsync and
//            qualifies the timing with a SEARCH/ACQUIRE/LOCKED tracker.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_receiver #(
    parameter int H_TOTAL = 800,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int H_DISP  = 640,
    parameter int V_TOTAL = 525,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int V_DISP  = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_tick,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err,
    output logic [7:0] err_cnt
);

    localparam logic [9:0] c_cnt_max = 10'd1023;
    localparam logic [9:0] c_h_last  = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_h_sync  = 10'(H_SYNC);
    localparam logic [9:0] c_h_tmo   = 10'(H_TOTAL + 15);
    localparam logic [9:0] c_v_last  = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_h_lo    = 10'(H_SYNC + H_BP);
    localparam logic [9:0] c_h_hi    = 10'(H_SYNC + H_BP + H_DISP - 1);
    localparam logic [9:0] c_v_lo    = 10'(V_SYNC + V_BP);
    localparam logic [9:0] c_v_hi    = 10'(V_SYNC + V_BP + V_DISP - 1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_hs_s1, r_hs_s2, r_vs_s1, r_vs_s2;
    logic       r_hs_prev, r_vs_prev;
    logic [9:0] r_hcnt, r_vcnt;
    logic [9:0] r_pixel_x, r_pixel_y;
    logic       r_video_on, r_frame_start, r_locked, r_sync_err;
    logic [7:0] r_err_cnt;

    logic       w_hs_fall, w_hs_rise, w_vs_start;
    logic [9:0] w_hcnt_nxt, w_vcnt_nxt;
    logic       w_err, w_locked_nxt, w_act;

    always_comb begin
        w_hs_fall  = pix_tick && r_hs_prev && !r_hs_s2;
        w_hs_rise  = pix_tick && !r_hs_prev && r_hs_s2;
        w_vs_start = w_hs_fall && r_vs_prev && !r_vs_s2;

        w_hcnt_nxt = r_hcnt;
        if (w_hs_fall)
            w_hcnt_nxt = '0;
        else if (pix_tick && (r_hcnt != c_cnt_max))
            w_hcnt_nxt = r_hcnt + 10'd1;

        w_vcnt_nxt = r_vcnt;
        if (w_vs_start)
            w_vcnt_nxt = '0;
        else if (w_hs_fall && (r_vcnt != c_cnt_max))
            w_vcnt_nxt = r_vcnt + 10'd1;

        // Sync width is judged on the count the rising tick lands on; the
        // timeout fires once, on the tick the count first reaches its limit.
        w_err = (r_state != ST_SEARCH) && (
                    (w_hs_fall  && (r_hcnt != c_h_last)) ||
                    (w_hs_rise  && (w_hcnt_nxt != c_h_sync)) ||
                    (w_vs_start && (r_vcnt != c_v_last)) ||
                    ((w_hcnt_nxt == c_h_tmo) && (r_hcnt != c_h_tmo)));

        w_locked_nxt = !w_err && ((r_state == ST_LOCKED) ||
                                  ((r_state == ST_ACQUIRE) && w_vs_start));

        w_act = (w_hcnt_nxt >= c_h_lo) && (w_hcnt_nxt <= c_h_hi) &&
                (w_vcnt_nxt >= c_v_lo) && (w_vcnt_nxt <= c_v_hi);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_SEARCH;
            r_hs_s1       <= 1'b1;
            r_hs_s2       <= 1'b1;
            r_vs_s1       <= 1'b1;
            r_vs_s2       <= 1'b1;
            r_hs_prev     <= 1'b1;
            r_vs_prev     <= 1'b1;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            r_hs_s1 <= hsync;
            r_hs_s2 <= r_hs_s1;
            r_vs_s1 <= vsync;
            r_vs_s2 <= r_vs_s1;
            if (pix_tick)
                r_hs_prev <= r_hs_s2;
            if (w_hs_fall)
                r_vs_prev <= r_vs_s2;
            r_hcnt <= w_hcnt_nxt;
            r_vcnt <= w_vcnt_nxt;

            case (r_state)
                ST_SEARCH:  if (w_vs_start) r_state <= ST_ACQUIRE;
                ST_ACQUIRE: if (w_err) r_state <= ST_SEARCH;
                            else if (w_vs_start) r_state <= ST_LOCKED;
                ST_LOCKED:  if (w_err) r_state <= ST_SEARCH;
                default:    r_state <= ST_SEARCH;
            endcase

            // Outputs are taken from next-state values so they move together
            // with the counters and the state.
            r_pixel_x     <= w_act ? (w_hcnt_nxt - c_h_lo) : '0;
            r_pixel_y     <= w_act ? (w_vcnt_nxt - c_v_lo) : '0;
            r_video_on    <= w_locked_nxt && w_act;
            r_frame_start <= w_vs_start && (r_state == ST_LOCKED) && !w_err;
            r_locked      <= w_locked_nxt;
            r_sync_err    <= w_err;
            if (w_err && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign video_on    = r_video_on;
    assign frame_start = r_frame_start;
    assign locked      = r_locked;
    assign sync_err    = r_sync_err;
    assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_receiver
// Brief    : Directed, table-driven bench for vga_sync_receiver on a scaled
//            40x12 timing so whole frames stay short.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_receiver;

    localparam int H_TOTAL = 40;
    localparam int H_SYNC  = 4;
    localparam int H_BP    = 4;
    localparam int H_DISP  = 24;
    localparam int V_TOTAL = 12;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 2;
    localparam int V_DISP  = 6;
    localparam int BUDGET  = 3 * H_TOTAL * V_TOTAL;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_tick = 1'b0;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on, frame_start, locked, sync_err;
    logic [7:0] err_cnt;

    vga_sync_receiver #(
        .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_DISP(H_DISP),
        .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_DISP(V_DISP)
    ) dut (
        .clk(clk), .rst(rst), .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .frame_start(frame_start), .locked(locked), .sync_err(sync_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         h;
        int         v;
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
    } vec_t;

    vec_t vecs[9];
    int   n_checks = 0;
    int   n_fail   = 0;
    // Generator position of the next pins to drive, and of the pins the DUT
    // has just consumed (it sees each tick's pins one tick later).
    int   gh, gv, last_h, last_v, dut_h, dut_v;
    int   hs_w = H_SYNC;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_tick(input logic hs, input logic vs);
        repeat (3) @(posedge clk);
        #1;
        hsync    = hs;
        vsync    = vs;
        pix_tick = 1'b1;
        @(posedge clk);
        #1;
        pix_tick = 1'b0;
    endtask

    task automatic ideal_tick();
        drive_tick(gh >= hs_w, gv >= V_SYNC);
        dut_h  = last_h;
        dut_v  = last_v;
        last_h = gh;
        last_v = gv;
        gh++;
        if (gh == H_TOTAL) begin
            gh = 0;
            gv = (gv + 1) % V_TOTAL;
        end
    endtask

    task automatic resync();
        gh = 0; gv = 6; last_h = -1; last_v = -1; dut_h = -1; dut_v = -1;
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        do begin
            ideal_tick();
            n++;
        end while (!((dut_h == h) && (dut_v == v)) && (n < BUDGET));
        if (!((dut_h == h) && (dut_v == v))) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_to(%0d,%0d): position not reached, at (%0d,%0d)", h, v, dut_h, dut_v);
        end
    endtask

    // One short line with vsync high, then one with vsync low and a 1-tick
    // sync pulse: enters ACQUIRE, then trips the width check.
    task automatic err_iter(output logic seen);
        drive_tick(1'b0, 1'b1);
        repeat (3) drive_tick(1'b1, 1'b1);
        drive_tick(1'b0, 1'b0);
        drive_tick(1'b1, 1'b0);
        drive_tick(1'b1, 1'b0);
        seen = sync_err;
        drive_tick(1'b1, 1'b0);
    endtask

    initial begin
        logic seen;
        int   errs;

        vecs[0] = '{h: 20, v: 3,  x: 10'd0,  y: 10'd0, von: 1'b0};
        vecs[1] = '{h: 7,  v: 4,  x: 10'd0,  y: 10'd0, von: 1'b0};
        vecs[2] = '{h: 8,  v: 4,  x: 10'd0,  y: 10'd0, von: 1'b1};
        vecs[3] = '{h: 9,  v: 4,  x: 10'd1,  y: 10'd0, von: 1'b1};
        vecs[4] = '{h: 31, v: 4,  x: 10'd23, y: 10'd0, von: 1'b1};
        vecs[5] = '{h: 32, v: 4,  x: 10'd0,  y: 10'd0, von: 1'b0};
        vecs[6] = '{h: 8,  v: 9,  x: 10'd0,  y: 10'd5, von: 1'b1};
        vecs[7] = '{h: 31, v: 9,  x: 10'd23, y: 10'd5, von: 1'b1};
        vecs[8] = '{h: 8,  v: 10, x: 10'd0,  y: 10'd0, von: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_pixel_x", pixel_x, 0);
        check("rst_video_on", video_on, 0);
        check("rst_locked", locked, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;

        // Partial first frame, ACQUIRE on frame 2, LOCKED on frame 3.
        resync();
        run_to(0, 0);
        check("acq_locked", locked, 0);
        run_to(12, 5);
        check("acq_video_on", video_on, 0);
        check("acq_pixel_x", pixel_x, 4);
        check("acq_pixel_y", pixel_y, 1);
        run_to(H_TOTAL - 1, V_TOTAL - 1);
        check("pre_lock_locked", locked, 0);
        run_to(0, 0);
        check("lock_locked", locked, 1);
        check("lock_frame_start", frame_start, 0);

        for (int i = 0; i < 9; i++) begin
            run_to(vecs[i].h, vecs[i].v);
            check($sformatf("vec%0d_x", i), pixel_x, vecs[i].x);
            check($sformatf("vec%0d_y", i), pixel_y, vecs[i].y);
            check($sformatf("vec%0d_von", i), video_on, vecs[i].von);
        end

        run_to(0, 0);
        check("frame4_frame_start", frame_start, 1);
        check("frame4_sync_err", sync_err, 0);

        // Short line while locked.
        run_to(H_TOTAL - 3, 5);
        gh = 0; gv = 6;
        ideal_tick();
        ideal_tick();
        check("short_sync_err", sync_err, 1);
        check("short_err_cnt", err_cnt, 1);
        check("short_locked", locked, 0);
        check("short_video_on", video_on, 0);
        run_to(0, 0);
        check("relock1_locked", locked, 0);
        run_to(0, 0);
        check("relock2_locked", locked, 1);

        // hsync stuck high: timeout when the count reaches H_TOTAL+15.
        run_to(10, 5);
        errs = 0;
        for (int i = 0; i < H_TOTAL + 15 - 11; i++) begin
            drive_tick(1'b1, 1'b1);
            errs += int'(sync_err);
        end
        check("tmo_early_err", errs, 0);
        check("tmo_early_locked", locked, 1);
        drive_tick(1'b1, 1'b1);
        check("tmo_sync_err", sync_err, 1);
        check("tmo_locked", locked, 0);
        check("tmo_err_cnt", err_cnt, 2);

        // Narrow sync pulse while in ACQUIRE.
        resync();
        run_to(0, 0);
        run_to(20, 2);
        check("width_pre_locked", locked, 0);
        hs_w = H_SYNC - 1;
        run_to(H_SYNC - 2, 3);
        check("width_pre_err", sync_err, 0);
        ideal_tick();
        hs_w = H_SYNC;
        check("width_sync_err", sync_err, 1);
        check("width_err_cnt", err_cnt, 3);
        run_to(0, 0);
        check("width_no_lock", locked, 0);

        // Width and timeout violations on the same tick count once.
        for (int i = 0; i < H_TOTAL + 13; i++) drive_tick(1'b0, 1'b1);
        drive_tick(1'b1, 1'b1);
        check("dual_pre_err", sync_err, 0);
        drive_tick(1'b1, 1'b1);
        check("dual_sync_err", sync_err, 1);
        check("dual_err_cnt", err_cnt, 4);

        for (int i = 0; i < 250; i++) err_iter(seen);
        check("burst_err_cnt_254", err_cnt, 254);
        for (int i = 0; i < 50; i++) err_iter(seen);
        check("burst_last_sync_err", seen, 1);
        check("burst_err_cnt_sat", err_cnt, 255);

        // Mid-line reset while locked.
        resync();
        run_to(0, 0);
        run_to(0, 0);
        check("rl_locked", locked, 1);
        run_to(15, 5);
        check("rl_video_on", video_on, 1);
        check("rl_pixel_x", pixel_x, 7);
        check("rl_pixel_y", pixel_y, 1);
        check("rl_err_cnt_hold", err_cnt, 255);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_pixel_x", pixel_x, 0);
        check("mrst_pixel_y", pixel_y, 0);
        check("mrst_video_on", video_on, 0);
        check("mrst_frame_start", frame_start, 0);
        check("mrst_locked", locked, 0);
        check("mrst_sync_err", sync_err, 0);
        check("mrst_err_cnt", err_cnt, 0);
        run_to(0, 0);
        check("mrst_acq_locked", locked, 0);
        run_to(0, 0);
        check("mrst_relock", locked, 1);
        check("mrst_relock_err_cnt", err_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
